// File: rtl/game_controller.sv
// Match sequencer for a two-player paddle game: serve hold, BCD countdown,
// edge-detected miss scoring, win/time-out detection and winner reporting.
module game_controller #(
   parameter int unsigned TICKS_PER_SEC = 25000000,
   parameter int unsigned GAME_SECONDS  = 60,
   parameter int unsigned SERVE_SECONDS = 2,
   parameter int unsigned WIN_SCORE     = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       miss1,
   input  logic       miss2,
   output logic       stop,
   output logic [3:0] sec1,
   output logic [3:0] sec0,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [1:0] winner,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SERVE = 2'd1,
      S_PLAY  = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   localparam int unsigned   CW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] TICK_LAST  = CW'(TICKS_PER_SEC - 1);
   localparam logic [3:0]    TENS_INIT  = 4'(GAME_SECONDS / 10);
   localparam logic [3:0]    UNITS_INIT = 4'(GAME_SECONDS % 10);
   localparam logic [3:0]    SERVE_LAST = 4'(SERVE_SECONDS - 1);
   localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

   state_t        state_q, state_d;
   logic [CW-1:0] presc_q, presc_d;
   logic [3:0]    serve_q, serve_d;
   logic [3:0]    sec1_q, sec1_d, sec0_q, sec0_d;
   logic [3:0]    score1_q, score1_d, score2_q, score2_d;
   logic [1:0]    winner_q, winner_d;
   logic          stop_q, stop_d;
   logic          start_q, miss1_q, miss2_q;

   logic tick, start_ev, m1_ev, m2_ev, scored;

   assign tick     = (presc_q == TICK_LAST);
   assign start_ev = start & ~start_q;
   assign m1_ev    = miss1 & ~miss1_q;
   assign m2_ev    = miss2 & ~miss2_q;
   assign scored   = m1_ev ^ m2_ev;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state plus score, clock and prescaler updates.
   always_comb begin
      state_d  = state_q;
      serve_d  = serve_q;
      sec1_d   = sec1_q;
      sec0_d   = sec0_q;
      score1_d = score1_q;
      score2_d = score2_q;
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start_ev) begin
               state_d  = S_SERVE;
               serve_d  = '0;
               score1_d = '0;
               score2_d = '0;
               sec1_d   = TENS_INIT;
               sec0_d   = UNITS_INIT;
            end
         end
         S_SERVE: begin
            if (tick) begin
               if (serve_q == SERVE_LAST) state_d = S_PLAY;
               else                       serve_d = serve_q + 4'd1;
            end
         end
         S_PLAY: begin
            if (m1_ev && !m2_ev && score2_q != 4'hF) score2_d = score2_q + 4'd1;
            if (m2_ev && !m1_ev && score1_q != 4'hF) score1_d = score1_q + 4'd1;
            if (tick && (sec1_q != 4'd0 || sec0_q != 4'd0)) begin
               if (sec0_q == 4'd0) begin
                  sec1_d = sec1_q - 4'd1;
                  sec0_d = 4'd9;
               end else begin
                  sec0_d = sec0_q - 4'd1;
               end
            end
            // The score lands before the time-out test, so a point scored on
            // the final tick still counts toward the winner.
            if (scored && (score1_d == WIN || score2_d == WIN))
               state_d = S_OVER;
            else if (tick && sec1_d == 4'd0 && sec0_d == 4'd0)
               state_d = S_OVER;
            else if (m1_ev || m2_ev) begin
               state_d = S_SERVE;
               serve_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      presc_d = (state_d != state_q || tick) ? '0 : presc_q + 1'b1;
   end

   // Registered output values derived from the next state.
   always_comb begin
      stop_d   = (state_d != S_PLAY);
      winner_d = 2'b00;
      if (state_d == S_OVER) begin
         if (state_q == S_OVER)         winner_d = winner_q;
         else if (score1_d > score2_d)  winner_d = 2'b01;
         else if (score2_d > score1_d)  winner_d = 2'b10;
         else                           winner_d = 2'b11;
      end
   end

   // Datapath, history and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         serve_q  <= '0;
         sec1_q   <= TENS_INIT;
         sec0_q   <= UNITS_INIT;
         score1_q <= '0;
         score2_q <= '0;
         winner_q <= 2'b00;
         stop_q   <= 1'b1;
         start_q  <= 1'b0;
         miss1_q  <= 1'b0;
         miss2_q  <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         serve_q  <= serve_d;
         sec1_q   <= sec1_d;
         sec0_q   <= sec0_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         winner_q <= winner_d;
         stop_q   <= stop_d;
         start_q  <= start;
         miss1_q  <= miss1;
         miss2_q  <= miss2;
      end
   end

   assign stop   = stop_q;
   assign sec1   = sec1_q;
   assign sec0   = sec0_q;
   assign score1 = score1_q;
   assign score2 = score2_q;
   assign winner = winner_q;
   assign phase  = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a tiny time base.
module tb_game_controller;

   logic       clk = 1'b0;
   logic       rst, start, miss1, miss2;
   logic       stop;
   logic [3:0] sec1, sec0, score1, score2;
   logic [1:0] winner, phase;

   int checks = 0;
   int fails  = 0;

   game_controller #(
      .TICKS_PER_SEC(4),
      .GAME_SECONDS (10),
      .SERVE_SECONDS(1),
      .WIN_SCORE    (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .miss1 (miss1),
      .miss2 (miss2),
      .stop  (stop),
      .sec1  (sec1),
      .sec0  (sec0),
      .score1(score1),
      .score2(score2),
      .winner(winner),
      .phase (phase)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_phase(input logic [1:0] p);
      int k = 0;
      while (phase !== p && k < 50) begin
         cyc();
         k++;
      end
      checks++;
      if (phase !== p) begin
         $display("FAIL wait_phase: phase=%0d required=%0d (timeout)", phase, p);
         fails++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; miss1 = 1'b0; miss2 = 1'b0;
      cyc(2);
      checks++;
      if ({phase, stop, score1, score2, winner, sec1, sec0} !== {2'd0, 1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 4'd0}) begin
         $display("FAIL reset: ph=%0d stop=%0b s1=%0d s2=%0d w=%0b t=%0h%0h required ph=0 stop=1 s=0/0 w=00 t=10",
                  phase, stop, score1, score2, winner, sec1, sec0);
         fails++;
      end
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_start;
      start = 1'b1;
      cyc();
      checks++;
      if ({phase, stop, sec1, sec0} !== {2'd1, 1'b1, 8'h10}) begin
         $display("FAIL start_serve: ph=%0d stop=%0b t=%0h%0h required ph=1 stop=1 t=10", phase, stop, sec1, sec0);
         fails++;
      end
      cyc(3);
      checks++;
      if (phase !== 2'd1) begin
         $display("FAIL serve_hold: ph=%0d required 1", phase);
         fails++;
      end
      cyc();
      checks++;
      if ({phase, stop} !== {2'd2, 1'b0}) begin
         $display("FAIL play_entry: ph=%0d stop=%0b required ph=2 stop=0", phase, stop);
         fails++;
      end
      cyc(4);
      checks++;
      if ({sec1, sec0} !== 8'h09) begin
         $display("FAIL first_tick: t=%0h%0h required 09", sec1, sec0);
         fails++;
      end
      start = 1'b0;
   endtask

   task automatic test_score;
      miss1 = 1'b1;
      cyc();
      checks++;
      if ({score1, score2, phase, stop} !== {4'd0, 4'd1, 2'd1, 1'b1}) begin
         $display("FAIL miss1_score: s1=%0d s2=%0d ph=%0d stop=%0b required 0/1 ph=1 stop=1",
                  score1, score2, phase, stop);
         fails++;
      end
      cyc(19);
      checks++;
      if ({score1, score2} !== {4'd0, 4'd1}) begin
         $display("FAIL miss1_held: s1=%0d s2=%0d required 0/1", score1, score2);
         fails++;
      end
      miss1 = 1'b0;
      cyc();
   endtask

   task automatic test_simultaneous;
      wait_phase(2'd2);
      miss1 = 1'b1; miss2 = 1'b1;
      cyc();
      checks++;
      if ({score1, score2, phase} !== {4'd0, 4'd1, 2'd1}) begin
         $display("FAIL simul_miss: s1=%0d s2=%0d ph=%0d required 0/1 ph=1", score1, score2, phase);
         fails++;
      end
      miss1 = 1'b0; miss2 = 1'b0;
      cyc();
   endtask

   task automatic test_win;
      for (int i = 0; i < 3; i++) begin
         wait_phase(2'd2);
         miss2 = 1'b1;
         cyc();
         miss2 = 1'b0;
         cyc();
      end
      checks++;
      if ({score1, phase, winner, stop} !== {4'd3, 2'd3, 2'b01, 1'b1}) begin
         $display("FAIL win: s1=%0d ph=%0d w=%0b stop=%0b required s1=3 ph=3 w=01 stop=1",
                  score1, phase, winner, stop);
         fails++;
      end
      start = 1'b1;
      cyc();
      checks++;
      if ({score1, score2, sec1, sec0, phase, winner} !== {4'd0, 4'd0, 8'h10, 2'd1, 2'b00}) begin
         $display("FAIL restart: s=%0d/%0d t=%0h%0h ph=%0d w=%0b required 0/0 t=10 ph=1 w=00",
                  score1, score2, sec1, sec0, phase, winner);
         fails++;
      end
      start = 1'b0;
   endtask

   task automatic test_timeout;
      logic [7:0] exp_t;
      wait_phase(2'd2);
      checks++;
      if ({sec1, sec0} !== 8'h10) begin
         $display("FAIL timeout_begin: t=%0h%0h required 10", sec1, sec0);
         fails++;
      end
      for (int s = 9; s >= 1; s--) begin
         cyc(4);
         exp_t = 8'(s);
         checks++;
         if ({sec1, sec0} !== exp_t || phase !== 2'd2) begin
            $display("FAIL countdown: t=%0h%0h ph=%0d required %0h ph=2", sec1, sec0, phase, exp_t);
            fails++;
         end
      end
      cyc(4);
      checks++;
      if ({sec1, sec0, phase, winner, stop} !== {8'h00, 2'd3, 2'b11, 1'b1}) begin
         $display("FAIL timeout_draw: t=%0h%0h ph=%0d w=%0b stop=%0b required 00 ph=3 w=11 stop=1",
                  sec1, sec0, phase, winner, stop);
         fails++;
      end
   endtask

   task automatic test_timeout_with_miss;
      start = 1'b1;
      cyc();
      start = 1'b0;
      wait_phase(2'd2);
      cyc(36);
      checks++;
      if ({sec1, sec0} !== 8'h01) begin
         $display("FAIL last_second: t=%0h%0h required 01", sec1, sec0);
         fails++;
      end
      cyc(3);
      miss1 = 1'b1;
      cyc();
      checks++;
      if ({sec1, sec0, score2, phase, winner} !== {8'h00, 4'd1, 2'd3, 2'b10}) begin
         $display("FAIL timeout_miss: t=%0h%0h s2=%0d ph=%0d w=%0b required 00 s2=1 ph=3 w=10",
                  sec1, sec0, score2, phase, winner);
         fails++;
      end
      miss1 = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid_play;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         wait_phase(2'd2);
         miss2 = 1'b1;
         cyc();
         miss2 = 1'b0;
         cyc();
      end
      wait_phase(2'd2);
      start = 1'b1;
      cyc();
      checks++;
      if ({score1, phase} !== {4'd2, 2'd2}) begin
         $display("FAIL start_in_play: s1=%0d ph=%0d required s1=2 ph=2", score1, phase);
         fails++;
      end
      start = 1'b0;
      miss2 = 1'b1;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({phase, stop, score1, score2, winner, sec1, sec0} !== {2'd0, 1'b1, 4'd0, 4'd0, 2'b00, 8'h10}) begin
         $display("FAIL async_reset: ph=%0d stop=%0b s=%0d/%0d w=%0b t=%0h%0h required ph=0 stop=1 s=0/0 w=00 t=10",
                  phase, stop, score1, score2, winner, sec1, sec0);
         fails++;
      end
      cyc();
      checks++;
      if ({phase, score1} !== {2'd0, 4'd0}) begin
         $display("FAIL reset_held: ph=%0d s1=%0d required ph=0 s1=0", phase, score1);
         fails++;
      end
      miss2 = 1'b0;
      rst = 1'b0;
      cyc();
   endtask

   initial begin
      test_reset();
      test_start();
      test_score();
      test_simultaneous();
      test_win();
      test_timeout();
      test_timeout_with_miss();
      test_reset_mid_play();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 25000000, meaning clk cycles per game second.
REQ-002 The block SHALL have parameter GAME_SECONDS, default 60, meaning the match length in seconds (legal range 1..99).
REQ-003 The block SHALL have parameter SERVE_SECONDS, default 2, meaning the hold time before each serve (legal range 1..15).
REQ-004 The block SHALL have parameter WIN_SCORE, default 9, meaning the points that end the match (legal range 1..15).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port start, input, 1 bit: synchronous start button level.
REQ-008 The block SHALL have port miss1, input, 1 bit: player1 missed, level from the ball/paddle state machine.
REQ-009 The block SHALL have port miss2, input, 1 bit: player2 missed, level from the ball/paddle state machine.
REQ-010 The block SHALL have port stop, output, 1 bit: freeze and recentre the ball and paddles.
REQ-011 The block SHALL have port sec1, output, 4 bits: BCD tens digit of the remaining seconds.
REQ-012 The block SHALL have port sec0, output, 4 bits: BCD units digit of the remaining seconds.
REQ-013 The block SHALL have port score1, output, 4 bits: player1 points.
REQ-014 The block SHALL have port score2, output, 4 bits: player2 points.
REQ-015 The block SHALL have port winner, output, 2 bits: 00 none, 01 player1, 10 player2, 11 draw.
REQ-016 The block SHALL have port phase, output, 2 bits: 0 IDLE, 1 SERVE, 2 PLAY, 3 OVER.

Function
REQ-017 The FSM SHALL have states IDLE, SERVE, PLAY and OVER; all outputs SHALL be registered.
REQ-018 stop SHALL be 1 in IDLE, SERVE and OVER, and 0 only in PLAY.
REQ-019 A tick SHALL be a one-cycle pulse from a prescaler that counts 0..TICKS_PER_SEC-1; the prescaler SHALL clear on every state change.
REQ-020 IDLE -> SERVE SHALL occur on a start rising edge (start=1 with previous start=0); scores SHALL clear and the time SHALL load GAME_SECONDS on that edge.
REQ-021 SERVE SHALL last exactly SERVE_SECONDS ticks, then go to PLAY; the time SHALL be frozen in SERVE.
REQ-022 In PLAY, each tick SHALL decrement {sec1,sec0} as BCD (x0 -> (x-1)9), never below 00.
REQ-023 Misses SHALL be edge-detected: a miss event is missN=1 with previous missN=0, and events SHALL count only in PLAY.
REQ-024 A miss1 event alone SHALL increment score2; a miss2 event alone SHALL increment score1; both in the same cycle SHALL score nothing.
REQ-025 Any miss event in PLAY SHALL transition to SERVE on the next cycle, unless REQ-026 applies.
REQ-026 The FSM SHALL go PLAY -> OVER when an updated score equals WIN_SCORE or the time reaches 00; a score and time-out in the same cycle SHALL apply the score first.
REQ-027 On entering OVER, winner SHALL be set to the higher score, or 11 if the scores are equal; winner SHALL be 00 in all other states.
REQ-028 Scores SHALL saturate at 15 and never wrap.
REQ-029 OVER -> SERVE SHALL occur on a start rising edge, performing the same clears and loads as REQ-020.
REQ-030 start held high SHALL NOT retrigger; miss levels held high SHALL count once.

Reset
REQ-031 While rst=1: phase=IDLE, stop=1, score1=score2=0, winner=00, {sec1,sec0}=GAME_SECONDS in BCD, prescaler=0, and edge-detect history=0.
REQ-032 rst asserted mid-match SHALL abort immediately to the REQ-031 values, with no partial score update.

Verification (TICKS_PER_SEC=4, GAME_SECONDS=10, SERVE_SECONDS=1, WIN_SCORE=3)
REQ-033 Start: after reset, pulse start -> phase=SERVE next cycle, stop=1, time=10; PLAY 4 cycles later; after 4 more cycles time=09.
REQ-034 Scoring: in PLAY, hold miss1 high for 20 cycles -> score2=1 exactly once, phase=SERVE, stop=1.
REQ-035 Simultaneous misses: miss1 and miss2 rise in the same cycle -> scores unchanged, phase=SERVE.
REQ-036 Win: three separate miss2 events -> score1=3, phase=OVER, winner=01, stop=1; a further start edge -> scores 0, time=10, phase=SERVE.
REQ-037 Time-out: no misses for 10 game seconds -> 10,09..01,00, then phase=OVER, winner=11; a miss in the same cycle as the 00 tick -> score applied, winner reflects it.
REQ-038 Reset mid-PLAY with score1=2: assert rst asynchronously -> the REQ-031 values appear without waiting for a clock edge.
